// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Brief    : Instruction-memory handshake and IF/ID bus of the fetch stage.
// Revision : 1.0
// ============================================================================
interface fetch_stage_if #(
    parameter int WORD_SIZE = 16
);
    logic                 i_mem_req;
    logic [WORD_SIZE-1:0] i_mem_addr;
    logic [WORD_SIZE-1:0] i_mem_data;
    logic                 i_mem_ready;
    logic                 stall;
    logic                 redirect;
    logic [WORD_SIZE-1:0] redirect_target;
    logic                 if_id_valid;
    logic [WORD_SIZE-1:0] if_id_inst;
    logic [WORD_SIZE-1:0] if_id_pc;
    logic [WORD_SIZE-1:0] if_id_pc_plus1;
    logic [3:0]           opcode;
    logic [5:0]           func_code;
    logic [15:0]          fetch_count;

    modport master (
        output i_mem_req, i_mem_addr,
        input  i_mem_data, i_mem_ready,
        input  stall, redirect, redirect_target,
        output if_id_valid, if_id_inst, if_id_pc, if_id_pc_plus1,
        output opcode, func_code, fetch_count
    );

    modport slave (
        input  i_mem_req, i_mem_addr,
        output i_mem_data, i_mem_ready,
        output stall, redirect, redirect_target,
        input  if_id_valid, if_id_inst, if_id_pc, if_id_pc_plus1,
        input  opcode, func_code, fetch_count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : PC, instruction-memory handshake, skid buffer and IF/ID register.
// Revision : 1.0
// ============================================================================
module fetch_stage #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = 16'h0000
) (
    input  logic           clk,
    input  logic           reset_n,
    fetch_stage_if.master  bus
);
    typedef enum logic [1:0] {
        WAIT_RST = 2'd0,
        FETCH    = 2'd1,
        BUF      = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] buf_inst_q, buf_inst_d;
    logic [WORD_SIZE-1:0] buf_pc_q, buf_pc_d;
    logic [WORD_SIZE-1:0] tgt_q, tgt_d;
    logic                 valid_q, valid_d;
    logic [WORD_SIZE-1:0] inst_q, inst_d;
    logic [WORD_SIZE-1:0] ifpc_q, ifpc_d;
    logic [15:0]          count_q, count_d;
    logic                 mem_req;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= WAIT_RST;
            pc_q       <= RESET_PC;
            buf_inst_q <= '0;
            buf_pc_q   <= '0;
            tgt_q      <= '0;
            valid_q    <= 1'b0;
            inst_q     <= '0;
            ifpc_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_inst_q <= buf_inst_d;
            buf_pc_q   <= buf_pc_d;
            tgt_q      <= tgt_d;
            valid_q    <= valid_d;
            inst_q     <= inst_d;
            ifpc_q     <= ifpc_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_inst_d = buf_inst_q;
        buf_pc_d   = buf_pc_q;
        tgt_d      = tgt_q;
        valid_d    = valid_q;
        inst_d     = inst_q;
        ifpc_d     = ifpc_q;
        count_d    = count_q;
        mem_req    = 1'b0;

        case (state_q)
            WAIT_RST: begin
                state_d = FETCH;
                if (bus.redirect) begin
                    pc_d = bus.redirect_target;
                end
            end

            FETCH: begin
                mem_req = 1'b1;
                if (bus.redirect) begin
                    valid_d = 1'b0;
                    if (bus.i_mem_ready) begin
                        pc_d = bus.redirect_target;
                    end else begin
                        // The request must still complete; its word is discarded in DRAIN.
                        tgt_d   = bus.redirect_target;
                        state_d = DRAIN;
                    end
                end else if (bus.i_mem_ready) begin
                    pc_d = pc_q + WORD_SIZE'(1);
                    if (bus.stall) begin
                        buf_inst_d = bus.i_mem_data;
                        buf_pc_d   = pc_q;
                        state_d    = BUF;
                    end else begin
                        valid_d = 1'b1;
                        inst_d  = bus.i_mem_data;
                        ifpc_d  = pc_q;
                        count_d = count_q + 16'd1;
                    end
                end else if (!bus.stall) begin
                    valid_d = 1'b0;
                end
            end

            BUF: begin
                if (bus.redirect) begin
                    valid_d = 1'b0;
                    pc_d    = bus.redirect_target;
                    state_d = FETCH;
                end else if (!bus.stall) begin
                    valid_d = 1'b1;
                    inst_d  = buf_inst_q;
                    ifpc_d  = buf_pc_q;
                    count_d = count_q + 16'd1;
                    state_d = FETCH;
                end
            end

            DRAIN: begin
                mem_req = 1'b1;
                valid_d = 1'b0;
                if (bus.i_mem_ready) begin
                    pc_d    = bus.redirect ? bus.redirect_target : tgt_q;
                    state_d = FETCH;
                end else if (bus.redirect) begin
                    tgt_d = bus.redirect_target;
                end
            end

            default: begin
                state_d = WAIT_RST;
            end
        endcase
    end

    assign bus.i_mem_req      = mem_req;
    assign bus.i_mem_addr     = pc_q;
    assign bus.if_id_valid    = valid_q;
    assign bus.if_id_inst     = inst_q;
    assign bus.if_id_pc       = ifpc_q;
    assign bus.if_id_pc_plus1 = ifpc_q + WORD_SIZE'(1);
    assign bus.opcode         = inst_q[WORD_SIZE-1 -: 4];
    assign bus.func_code      = inst_q[5:0];
    assign bus.fetch_count    = count_q;
endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed bench for fetch_stage; memory returns 16'h1000 + address.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_stage;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    logic        r_manual;
    logic        r_man_ready;
    int          r_wait_n;
    int          r_cnt;

    fetch_stage_if #(.WORD_SIZE(16)) bus();

    fetch_stage #(
        .WORD_SIZE (16),
        .RESET_PC  (16'h0000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait-state memory: ready after r_wait_n extra request cycles, or driven by hand.
    assign bus.i_mem_ready = r_manual ? r_man_ready
                                      : (bus.i_mem_req && (r_cnt == r_wait_n));
    assign bus.i_mem_data  = 16'h1000 + bus.i_mem_addr;

    always @(posedge clk) begin
        if (!bus.i_mem_req || bus.i_mem_ready) r_cnt <= 0;
        else                                   r_cnt <= r_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        r_cnt = 0;
        r_manual = 1'b0;
        r_man_ready = 1'b0;
        r_wait_n = 0;
        reset_n = 1'b0;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_target = 16'h0000;
        step();
        step();
        check("rst_valid", {15'd0, bus.if_id_valid}, 16'd0);
        check("rst_inst",  bus.if_id_inst, 16'h0000);
        check("rst_pc",    bus.if_id_pc, 16'h0000);
        check("rst_count", bus.fetch_count, 16'd0);
        check("rst_req",   {15'd0, bus.i_mem_req}, 16'd0);

        // Zero-wait streaming
        reset_n = 1'b1;
        check("waitrst_req", {15'd0, bus.i_mem_req}, 16'd0);
        step();
        check("first_addr", bus.i_mem_addr, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            step();
            check("zw_valid", {15'd0, bus.if_id_valid}, 16'd1);
            check("zw_pc",    bus.if_id_pc, 16'(i));
            check("zw_inst",  bus.if_id_inst, 16'h1000 + 16'(i));
        end
        check("zw_count",  bus.fetch_count, 16'd4);
        check("zw_opcode", {12'd0, bus.opcode}, 16'h0001);
        check("zw_plus1",  bus.if_id_pc_plus1, 16'h0004);
        step();
        check("pre_stall_pc", bus.if_id_pc, 16'h0004);

        // Stall for 3 cycles while the word for pc 5 is ready
        bus.stall = 1'b1;
        check("stall_addr", bus.i_mem_addr, 16'h0005);
        step();
        check("buf_req", {15'd0, bus.i_mem_req}, 16'd0);
        check("buf_hold_pc", bus.if_id_pc, 16'h0004);
        step();
        step();
        check("buf_req2", {15'd0, bus.i_mem_req}, 16'd0);
        check("buf_hold_pc2", bus.if_id_pc, 16'h0004);
        check("buf_count", bus.fetch_count, 16'd5);
        bus.stall = 1'b0;
        step();
        check("release_pc",   bus.if_id_pc, 16'h0005);
        check("release_func", {10'd0, bus.func_code}, 16'h0005);
        check("release_count", bus.fetch_count, 16'd6);
        check("resume_addr", bus.i_mem_addr, 16'h0006);
        check("resume_req",  {15'd0, bus.i_mem_req}, 16'd1);
        step();
        check("resume_pc", bus.if_id_pc, 16'h0006);
        check("resume_count", bus.fetch_count, 16'd7);

        // Two-wait memory: addresses 7 and 8
        r_wait_n = 2;
        for (int w = 0; w < 2; w++) begin
            for (int c = 0; c < 3; c++) begin
                check("w2_req",  {15'd0, bus.i_mem_req}, 16'd1);
                check("w2_addr", bus.i_mem_addr, 16'h0007 + 16'(w));
                step();
                check("w2_valid", {15'd0, bus.if_id_valid}, (c == 2) ? 16'd1 : 16'd0);
            end
            check("w2_pc", bus.if_id_pc, 16'h0007 + 16'(w));
        end
        check("w2_count", bus.fetch_count, 16'd9);

        // Redirect to 0x0040 with the request for pc 9 outstanding
        r_wait_n = 0;
        r_manual = 1'b1;
        r_man_ready = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_target = 16'h0040;
        step();
        bus.redirect = 1'b0;
        check("drain_valid", {15'd0, bus.if_id_valid}, 16'd0);
        check("drain_addr",  bus.i_mem_addr, 16'h0009);
        check("drain_req",   {15'd0, bus.i_mem_req}, 16'd1);
        step();
        r_man_ready = 1'b1;
        check("drain_addr2", bus.i_mem_addr, 16'h0009);
        step();
        r_manual = 1'b0;
        r_man_ready = 1'b0;
        check("tgt_addr",  bus.i_mem_addr, 16'h0040);
        check("tgt_valid", {15'd0, bus.if_id_valid}, 16'd0);
        check("tgt_count", bus.fetch_count, 16'd9);
        step();
        check("tgt_pc",   bus.if_id_pc, 16'h0040);
        check("tgt_inst", bus.if_id_inst, 16'h1040);
        check("tgt_count2", bus.fetch_count, 16'd10);

        // Redirect and stall together while in BUF
        bus.stall = 1'b1;
        step();
        bus.redirect = 1'b1;
        bus.redirect_target = 16'hFFFF;
        step();
        bus.redirect = 1'b0;
        bus.stall = 1'b0;
        check("flush_valid", {15'd0, bus.if_id_valid}, 16'd0);
        check("flush_count", bus.fetch_count, 16'd10);
        check("flush_addr",  bus.i_mem_addr, 16'hFFFF);
        step();
        check("wrap_pc",    bus.if_id_pc, 16'hFFFF);
        check("wrap_inst",  bus.if_id_inst, 16'h0FFF);
        check("wrap_func",  {10'd0, bus.func_code}, 16'h003F);
        check("wrap_opc",   {12'd0, bus.opcode}, 16'h0000);
        check("wrap_plus1", bus.if_id_pc_plus1, 16'h0000);
        check("wrap_addr",  bus.i_mem_addr, 16'h0000);
        step();
        check("nobuf_pc",   bus.if_id_pc, 16'h0000);
        check("nobuf_inst", bus.if_id_inst, 16'h1000);
        check("nobuf_count", bus.fetch_count, 16'd12);

        // Reset during DRAIN with ready arriving in the reset cycle
        r_manual = 1'b1;
        r_man_ready = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_target = 16'h0100;
        step();
        bus.redirect = 1'b0;
        r_man_ready = 1'b1;
        reset_n = 1'b0;
        step();
        r_manual = 1'b0;
        r_man_ready = 1'b0;
        check("mrst_valid", {15'd0, bus.if_id_valid}, 16'd0);
        check("mrst_inst",  bus.if_id_inst, 16'h0000);
        check("mrst_pc",    bus.if_id_pc, 16'h0000);
        check("mrst_count", bus.fetch_count, 16'd0);
        check("mrst_req",   {15'd0, bus.i_mem_req}, 16'd0);
        reset_n = 1'b1;
        step();
        check("mrst_addr", bus.i_mem_addr, 16'h0000);
        check("mrst_req2", {15'd0, bus.i_mem_req}, 16'd1);
        step();
        check("mrst_fpc",   bus.if_id_pc, 16'h0000);
        check("mrst_finst", bus.if_id_inst, 16'h1000);
        check("mrst_fcnt",  bus.fetch_count, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined 16-bit CPU; sits directly upstream of the decode-stage control unit. Holds the PC and runs a request/ready handshake with instruction memory, then latches fetched words into IF/ID. Presents `opcode`/`func_code` to decode. Supports hazard stalls, a one-entry skid buffer, and flush/redirect on taken jumps and branches resolved downstream.

## Interface
- `WORD_SIZE`, 16, instruction/PC width (fixed at 16 for this ISA)
- `RESET_PC`, 16'h0000, PC value after reset
- `clk`  in  1  clock; all state on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `i_mem_req`  out  1  instruction read request
- `i_mem_addr`  out  16  read address, stable while `i_mem_req`=1 until `i_mem_ready`
- `i_mem_data`  in  16  instruction word, valid when `i_mem_ready`=1
- `i_mem_ready`  in  1  response valid this cycle (may be same cycle as request)
- `stall`  in  1  hazard unit: hold IF/ID contents
- `redirect`  in  1  taken jump/branch resolved this cycle; flush and refetch
- `redirect_target`  in  16  new PC when `redirect`=1
- `if_id_valid`  out  1  IF/ID holds a real instruction
- `if_id_inst`  out  16  latched instruction
- `if_id_pc`  out  16  address of latched instruction
- `if_id_pc_plus1`  out  16  `if_id_pc`+1 (mod 2^16)
- `opcode`  out  4  `if_id_inst[15:12]`
- `func_code`  out  6  `if_id_inst[5:0]`
- `fetch_count`  out  16  number of instructions delivered into IF/ID

## Operation
- States: WAIT_RST, FETCH, BUF, DRAIN.
- WAIT_RST: `i_mem_req`=0. Next edge goes to FETCH.
- FETCH: `i_mem_req`=1, `i_mem_addr`=pc.
  - ready and !stall: load IF/ID {valid=1, inst, pc}; pc<=pc+1; stay in FETCH.
  - ready and stall: capture word and pc into the skid buffer; pc<=pc+1; go to BUF.
  - !ready and !stall: `if_id_valid`<=0 (bubble).
  - !ready and stall: IF/ID holds.
- BUF: `i_mem_req`=0; IF/ID holds while stall. On !stall, load IF/ID from the buffer and go to FETCH.
- DRAIN: `i_mem_req`=1 and `i_mem_addr` holds the abandoned address. On ready, discard the data, set pc<=saved target, and go to FETCH. `if_id_valid`=0 throughout.
- Redirect takes priority over stall in every state:
  - `if_id_valid`<=0.
  - FETCH with ready=1: drop the data; pc<=target; stay in FETCH.
  - FETCH with ready=0: save the target; go to DRAIN (no abandoned handshake).
  - BUF: drop the buffer; pc<=target; go to FETCH.
  - DRAIN: overwrite the saved target.
- `if_id_pc_plus1`, `opcode` and `func_code` are combinational from the IF/ID register.
- PC arithmetic wraps modulo 2^16 (16'hFFFF+1 = 16'h0000).
- `fetch_count` increments by 1 on each edge where IF/ID is newly loaded with valid=1 (FETCH or BUF path); it does not increment on hold. Wraps at 16'hFFFF.
- Reset (any state, including mid-handshake): state<=WAIT_RST, pc<=RESET_PC, buffer cleared, `if_id_valid`=0, `if_id_inst`=0, `if_id_pc`=0, `fetch_count`=0, `i_mem_req`=0. Any late memory response is ignored.

## Timing
- First edge with reset_n=1 goes WAIT_RST→FETCH. With zero-wait memory, IF/ID is valid with the RESET_PC instruction after the next edge.
- Steady state with zero-wait memory and no stall: 1 instruction per cycle into IF/ID.
- N-wait memory: `i_mem_req` is asserted for N+1 cycles per word; IF/ID loads on the edge closing the ready cycle.
- Redirect in cycle t (FETCH, ready=1): target requested in t+1; IF/ID valid with the target instruction at the end of t+1, giving a 1-bubble penalty.
- Redirect while a request is outstanding: target requested the cycle after the abandoned request's ready.
- Stall release from BUF: buffered instruction appears in IF/ID at the edge ending the first !stall cycle; the next fetch request starts the following cycle.

## Test plan
- Reset, zero-wait memory returning mem[a]=16'h1000+a, 5 cycles -> IF/ID gives pc 0,1,2,3 on consecutive edges; `fetch_count`=4; `opcode`=4'h1.
- 2-wait memory -> `i_mem_req` high 3 cycles per address with stable `i_mem_addr`; `if_id_valid` pattern 0,0,1 repeating.
- stall=1 for 3 cycles while ready=1 at pc=5 -> BUF entered; `i_mem_req`=0; IF/ID holds pc 4; on release IF/ID=pc 5, then fetch resumes at 6; `fetch_count` does not double-count.
- Redirect to 16'h0040 with ready=0 at pc=9, ready after 2 cycles -> DRAIN; word for 9 discarded; next request addr 16'h0040; `if_id_valid`=0 until the target instruction loads.
- redirect=1 and stall=1 in the same cycle from BUF -> IF/ID flushed (valid=0), buffer dropped, fetch at target; pc=16'hFFFF fetch -> next `i_mem_addr`=16'h0000.
- reset_n=0 asserted mid-DRAIN with ready arriving that cycle -> all outputs return to reset values; first fetch after release is RESET_PC.
